hdr_seq_ctrl: RTL and testbench
===============================

HDR_SEQ_CTRL -- requirements
Module: hdr_seq_ctrl

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, giving the depth of the eth header-result FIFO and the maximum number of headers not yet popped.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, giving the width of the statistics counters.
REQ-003 SHALL have ports: clk in 1 (single clock); reset in 1, asynchronous, active-high.
REQ-004 SHALL have ports: i_tvalid in 1, upstream beat valid; i_tlast in 1, last beat; i_tready_ds in 1, downstream ready; o_tready out 1, upstream ready.
REQ-005 SHALL have port o_pkt_word1 out 1, which strobes the parser on a first-word beat.
REQ-006 SHALL have ports: i_eth_valid in 1, parser FIFO non-empty; i_is_bmcast, i_is_for_us, i_is_arp, i_is_ipv4 in 1 each, FIFO head flags; o_rd_eth out 1, FIFO pop.
REQ-007 SHALL have ports: o_dec_valid out 1; o_dec_action out 2 (00 drop, 01 forward, 10 to-CPU); i_dec_ready in 1.
REQ-008 SHALL have ports: o_drop_cnt out CNT_WIDTH; o_cpu_cnt out CNT_WIDTH; o_outstanding out clog2(MAX_OUTSTANDING)+1, the current header count.

Function
REQ-009 A beat SHALL be defined as i_tvalid & o_tready.
REQ-010 The FSM SHALL have two states, S_HDR and S_BODY.
- S_HDR + beat + !i_tlast -> S_BODY.
- S_HDR + beat + i_tlast -> S_HDR (single-beat packet).
- S_BODY + beat + i_tlast -> S_HDR.
- Otherwise the FSM SHALL hold state.
REQ-011 o_pkt_word1 SHALL be combinational and equal to (state==S_HDR) & beat.
REQ-012 o_tready SHALL be combinational and equal to i_tready_ds & !(state==S_HDR & outstanding==MAX_OUTSTANDING); stalls SHALL occur only at packet boundaries, never mid-packet.
REQ-013 The outstanding count SHALL change as follows:
- +1 on o_pkt_word1.
- -1 on o_rd_eth.
- Unchanged when both occur in the same cycle.
- It SHALL never exceed MAX_OUTSTANDING nor go below 0.
REQ-014 o_rd_eth SHALL be combinational and equal to i_eth_valid & (!o_dec_valid | i_dec_ready); it SHALL assert for exactly one cycle per FIFO entry consumed.
REQ-015 On o_rd_eth, the decision register SHALL load on the next clock edge with o_dec_valid=1 and o_dec_action set by:
- 00 if !i_is_for_us.
- else 01 if i_is_ipv4 & !i_is_bmcast.
- else 10.
- Code 11 SHALL never be produced.
REQ-016 o_dec_valid SHALL clear on the edge where o_dec_valid & i_dec_ready & !o_rd_eth.
REQ-017 When the head decision is accepted and a new entry is popped in the same cycle, the register SHALL reload without a bubble, giving one decision per cycle at full throughput.
REQ-018 o_dec_action and o_dec_valid SHALL hold stable while o_dec_valid & !i_dec_ready.
REQ-019 o_drop_cnt SHALL increment by 1 on each load of action 00, and o_cpu_cnt on each load of action 10; both SHALL saturate at all-ones with no wrap.
REQ-020 Latency SHALL be 1 cycle from o_rd_eth to o_dec_valid.

Reset
REQ-021 Asserting reset SHALL immediately force the following, independent of clk:
- state=S_HDR; outstanding=0; o_dec_valid=0; o_dec_action=00; o_drop_cnt=0; o_cpu_cnt=0.
- As a consequence, o_pkt_word1=0 and o_rd_eth=0 except as the combinational inputs dictate.
REQ-022 A reset asserted mid-packet SHALL discard the partial packet state; the first beat after reset SHALL be treated as a first word.
REQ-023 While reset is high, o_tready SHALL equal i_tready_ds (outstanding=0), and no register SHALL change.

Verification
REQ-024 The bench SHALL cover:
- 3-beat packet, i_tready_ds=1 -> o_pkt_word1 high on beat 1 only; FSM back in S_HDR after beat 3.
- Single-beat packet (tlast on beat 1) followed by a second packet -> o_pkt_word1 on both consecutive beats.
- 5 headers accepted with i_eth_valid held 0, MAX_OUTSTANDING=4 -> o_tready low at the 5th packet's first beat; o_outstanding=4; stall released the cycle after the first o_rd_eth.
- FIFO heads {for_us=1,ipv4=1,bmcast=0}, {for_us=0}, {for_us=1,bmcast=1,ipv4=1}, {for_us=1,arp=1} -> actions 01, 00, 10, 10; drop_cnt=1, cpu_cnt=2.
- i_dec_ready=0 with i_eth_valid=1 -> a single o_rd_eth, then o_rd_eth held low and the action held stable; raising i_dec_ready -> back-to-back pop and accept every cycle.
- Counter preset to 16'hFFFE plus 3 drops -> o_drop_cnt stays 16'hFFFF.
- Reset pulse during S_BODY with outstanding=2 -> outputs cleared asynchronously; the next beat asserts o_pkt_word1.

Source files
------------

// File: rtl/hdr_seq_ctrl.sv
// Header sequencing controller: tracks packet boundaries on an AXI-Stream-like input,
// limits headers in flight to the parser FIFO depth, and turns parsed headers into forward/drop/CPU decisions.
module hdr_seq_ctrl #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               i_tvalid,
  input  logic                               i_tlast,
  input  logic                               i_tready_ds,
  output logic                               o_tready,
  output logic                               o_pkt_word1,
  input  logic                               i_eth_valid,
  input  logic                               i_is_bmcast,
  input  logic                               i_is_for_us,
  input  logic                               i_is_arp,
  input  logic                               i_is_ipv4,
  output logic                               o_rd_eth,
  output logic                               o_dec_valid,
  output logic [1:0]                         o_dec_action,
  input  logic                               i_dec_ready,
  output logic [CNT_WIDTH-1:0]               o_drop_cnt,
  output logic [CNT_WIDTH-1:0]               o_cpu_cnt,
  output logic [$clog2(MAX_OUTSTANDING):0]   o_outstanding
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;

  localparam logic [0:0] S_HDR  = 1'b0;
  localparam logic [0:0] S_BODY = 1'b1;

  localparam logic [1:0] ACT_DROP = 2'b00;
  localparam logic [1:0] ACT_FWD  = 2'b01;
  localparam logic [1:0] ACT_CPU  = 2'b10;

  localparam logic [OUT_W-1:0]     OUT_MAX = OUT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [0:0]       state;
  logic [OUT_W-1:0] outstanding;
  logic             beat;
  logic             hdr_full;
  logic [1:0]       next_action;

  // Stall only while waiting for a first word, so a packet in flight is never split.
  assign hdr_full    = (state == S_HDR) && (outstanding == OUT_MAX);
  assign o_tready    = i_tready_ds & ~hdr_full;
  assign beat        = i_tvalid & o_tready;
  assign o_pkt_word1 = (state == S_HDR) & beat;

  // Pop whenever the decision register is empty or is being drained this cycle.
  assign o_rd_eth    = i_eth_valid & (~o_dec_valid | i_dec_ready);

  // Broadcast/multicast IPv4 goes to the CPU alongside ARP and other local traffic.
  always_comb begin
    next_action = ACT_CPU;
    if (!i_is_for_us)
      next_action = ACT_DROP;
    else if (i_is_ipv4 && !i_is_bmcast)
      next_action = ACT_FWD;
  end

  assign o_outstanding = outstanding;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_HDR;
      outstanding <= '0;
    end else begin
      if (beat) begin
        case (state)
          S_HDR:   if (!i_tlast) state <= S_BODY;
          S_BODY:  if (i_tlast)  state <= S_HDR;
          default: state <= S_HDR;
        endcase
      end
      if (o_pkt_word1 && !o_rd_eth && outstanding != OUT_MAX)
        outstanding <= outstanding + 1'b1;
      else if (!o_pkt_word1 && o_rd_eth && outstanding != '0)
        outstanding <= outstanding - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_dec_valid  <= 1'b0;
      o_dec_action <= ACT_DROP;
      o_drop_cnt   <= '0;
      o_cpu_cnt    <= '0;
    end else begin
      if (o_rd_eth) begin
        o_dec_valid  <= 1'b1;
        o_dec_action <= next_action;
        if (next_action == ACT_DROP && o_drop_cnt != CNT_MAX)
          o_drop_cnt <= o_drop_cnt + 1'b1;
        if (next_action == ACT_CPU && o_cpu_cnt != CNT_MAX)
          o_cpu_cnt <= o_cpu_cnt + 1'b1;
      end else if (o_dec_valid && i_dec_ready) begin
        o_dec_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hdr_seq_ctrl.sv
// Directed bench for hdr_seq_ctrl: inputs change on the falling edge, outputs are
// checked 1 ns later, and each task covers one scenario with hand-computed expectations.
module tb_hdr_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_tvalid, i_tlast, i_tready_ds;
  logic        o_tready, o_pkt_word1;
  logic        i_eth_valid, i_is_bmcast, i_is_for_us, i_is_arp, i_is_ipv4;
  logic        o_rd_eth, o_dec_valid, i_dec_ready;
  logic [1:0]  o_dec_action;
  logic [15:0] o_drop_cnt, o_cpu_cnt;
  logic [2:0]  o_outstanding;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hdr_seq_ctrl #(.MAX_OUTSTANDING(4), .CNT_WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_tvalid     (i_tvalid),
    .i_tlast      (i_tlast),
    .i_tready_ds  (i_tready_ds),
    .o_tready     (o_tready),
    .o_pkt_word1  (o_pkt_word1),
    .i_eth_valid  (i_eth_valid),
    .i_is_bmcast  (i_is_bmcast),
    .i_is_for_us  (i_is_for_us),
    .i_is_arp     (i_is_arp),
    .i_is_ipv4    (i_is_ipv4),
    .o_rd_eth     (o_rd_eth),
    .o_dec_valid  (o_dec_valid),
    .o_dec_action (o_dec_action),
    .i_dec_ready  (i_dec_ready),
    .o_drop_cnt   (o_drop_cnt),
    .o_cpu_cnt    (o_cpu_cnt),
    .o_outstanding(o_outstanding)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    i_tvalid = 1'b0; i_tlast = 1'b0; i_tready_ds = 1'b1;
    i_eth_valid = 1'b0; i_dec_ready = 1'b1;
    i_is_bmcast = 1'b0; i_is_for_us = 1'b0; i_is_arp = 1'b0; i_is_ipv4 = 1'b0;
  endtask

  task automatic set_head(input logic for_us, input logic ipv4, input logic bmcast, input logic arp);
    i_is_for_us = for_us; i_is_ipv4 = ipv4; i_is_bmcast = bmcast; i_is_arp = arp;
  endtask

  // Pulse reset inside the low clock phase, leaving the bench just after a falling edge.
  task automatic do_reset();
    idle();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    tests++; if (o_outstanding !== 3'd0) begin fails++; $display("FAIL rst_outstanding: got %0d want 0", o_outstanding); end
    tests++; if (o_dec_valid !== 1'b0 || o_dec_action !== 2'b00) begin fails++; $display("FAIL rst_dec: got v=%b a=%b want v=0 a=00", o_dec_valid, o_dec_action); end
    tests++; if (o_drop_cnt !== 16'd0 || o_cpu_cnt !== 16'd0) begin fails++; $display("FAIL rst_cnt: got drop=%h cpu=%h want 0/0", o_drop_cnt, o_cpu_cnt); end
    tests++; if (o_tready !== 1'b1 || o_pkt_word1 !== 1'b0) begin fails++; $display("FAIL rst_tready_hi: got tready=%b w1=%b want 1/0", o_tready, o_pkt_word1); end
    i_tready_ds = 1'b0; #1;
    tests++; if (o_tready !== 1'b0) begin fails++; $display("FAIL rst_tready_lo: got %b want 0", o_tready); end
    i_tready_ds = 1'b1;
  endtask

  task automatic test_three_beat();
    do_reset();
    i_tvalid = 1'b1; i_tlast = 1'b0; #1;
    tests++; if (o_pkt_word1 !== 1'b1) begin fails++; $display("FAIL tb3_beat1_w1: got %b want 1", o_pkt_word1); end
    cyc(); #1;
    tests++; if (o_pkt_word1 !== 1'b0 || o_outstanding !== 3'd1) begin fails++; $display("FAIL tb3_beat2: got w1=%b out=%0d want 0/1", o_pkt_word1, o_outstanding); end
    cyc(); i_tlast = 1'b1; #1;
    tests++; if (o_pkt_word1 !== 1'b0) begin fails++; $display("FAIL tb3_beat3_w1: got %b want 0", o_pkt_word1); end
    cyc(); #1;
    tests++; if (o_pkt_word1 !== 1'b1) begin fails++; $display("FAIL tb3_back_in_hdr: got w1=%b want 1", o_pkt_word1); end
    cyc(); i_tvalid = 1'b0; #1;
    tests++; if (o_outstanding !== 3'd2) begin fails++; $display("FAIL tb3_outstanding: got %0d want 2", o_outstanding); end
  endtask

  task automatic test_single_beat();
    do_reset();
    i_tvalid = 1'b1; i_tlast = 1'b1; #1;
    tests++; if (o_pkt_word1 !== 1'b1) begin fails++; $display("FAIL sb_first_w1: got %b want 1", o_pkt_word1); end
    cyc(); i_tlast = 1'b0; #1;
    tests++; if (o_pkt_word1 !== 1'b1) begin fails++; $display("FAIL sb_second_w1: got %b want 1", o_pkt_word1); end
    cyc(); i_tvalid = 1'b0; #1;
    tests++; if (o_outstanding !== 3'd2) begin fails++; $display("FAIL sb_outstanding: got %0d want 2", o_outstanding); end
  endtask

  task automatic test_stall();
    do_reset();
    i_tvalid = 1'b1; i_tlast = 1'b1;
    repeat (4) cyc();
    #1;
    tests++; if (o_tready !== 1'b0 || o_pkt_word1 !== 1'b0) begin fails++; $display("FAIL st_fifth_blocked: got tready=%b w1=%b want 0/0", o_tready, o_pkt_word1); end
    tests++; if (o_outstanding !== 3'd4) begin fails++; $display("FAIL st_full: got %0d want 4", o_outstanding); end
    cyc(); #1;
    tests++; if (o_tready !== 1'b0 || o_outstanding !== 3'd4) begin fails++; $display("FAIL st_hold: got tready=%b out=%0d want 0/4", o_tready, o_outstanding); end
    i_eth_valid = 1'b1; set_head(1'b1, 1'b1, 1'b0, 1'b0); #1;
    tests++; if (o_rd_eth !== 1'b1 || o_tready !== 1'b0) begin fails++; $display("FAIL st_pop: got rd=%b tready=%b want 1/0", o_rd_eth, o_tready); end
    cyc(); i_eth_valid = 1'b0; #1;
    tests++; if (o_tready !== 1'b1 || o_pkt_word1 !== 1'b1 || o_outstanding !== 3'd3) begin fails++; $display("FAIL st_release: got tready=%b w1=%b out=%0d want 1/1/3", o_tready, o_pkt_word1, o_outstanding); end
    cyc(); i_tvalid = 1'b0; #1;
    tests++; if (o_outstanding !== 3'd4) begin fails++; $display("FAIL st_refill: got %0d want 4", o_outstanding); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    i_tvalid = 1'b1; i_tlast = 1'b1;
    cyc();
    i_eth_valid = 1'b1; set_head(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); i_tvalid = 1'b0; i_eth_valid = 1'b0; #1;
    tests++; if (o_outstanding !== 3'd1) begin fails++; $display("FAIL sim_push_pop: got %0d want 1", o_outstanding); end
  endtask

  task automatic test_decisions();
    do_reset();
    i_eth_valid = 1'b1; set_head(1'b1, 1'b1, 1'b0, 1'b0); #1;
    tests++; if (o_rd_eth !== 1'b1 || o_dec_valid !== 1'b0) begin fails++; $display("FAIL dec_first_pop: got rd=%b v=%b want 1/0", o_rd_eth, o_dec_valid); end
    cyc(); set_head(1'b0, 1'b0, 1'b0, 1'b0); #1;
    tests++; if (o_dec_valid !== 1'b1 || o_dec_action !== 2'b01) begin fails++; $display("FAIL dec_fwd: got v=%b a=%b want 1/01", o_dec_valid, o_dec_action); end
    cyc(); set_head(1'b1, 1'b1, 1'b1, 1'b0); #1;
    tests++; if (o_dec_valid !== 1'b1 || o_dec_action !== 2'b00) begin fails++; $display("FAIL dec_drop: got v=%b a=%b want 1/00", o_dec_valid, o_dec_action); end
    cyc(); set_head(1'b1, 1'b0, 1'b0, 1'b1); #1;
    tests++; if (o_dec_valid !== 1'b1 || o_dec_action !== 2'b10) begin fails++; $display("FAIL dec_bmcast_cpu: got v=%b a=%b want 1/10", o_dec_valid, o_dec_action); end
    cyc(); i_eth_valid = 1'b0; #1;
    tests++; if (o_dec_valid !== 1'b1 || o_dec_action !== 2'b10) begin fails++; $display("FAIL dec_arp_cpu: got v=%b a=%b want 1/10", o_dec_valid, o_dec_action); end
    cyc(); #1;
    tests++; if (o_dec_valid !== 1'b0) begin fails++; $display("FAIL dec_clear: got v=%b want 0", o_dec_valid); end
    tests++; if (o_drop_cnt !== 16'd1 || o_cpu_cnt !== 16'd2) begin fails++; $display("FAIL dec_counts: got drop=%0d cpu=%0d want 1/2", o_drop_cnt, o_cpu_cnt); end
    tests++; if (o_outstanding !== 3'd0) begin fails++; $display("FAIL dec_no_underflow: got %0d want 0", o_outstanding); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    i_dec_ready = 1'b0; i_eth_valid = 1'b1; set_head(1'b1, 1'b1, 1'b0, 1'b0); #1;
    tests++; if (o_rd_eth !== 1'b1) begin fails++; $display("FAIL bp_single_pop: got rd=%b want 1", o_rd_eth); end
    cyc(); set_head(1'b0, 1'b0, 1'b0, 1'b0); #1;
    tests++; if (o_rd_eth !== 1'b0 || o_dec_valid !== 1'b1 || o_dec_action !== 2'b01) begin fails++; $display("FAIL bp_stall1: got rd=%b v=%b a=%b want 0/1/01", o_rd_eth, o_dec_valid, o_dec_action); end
    cyc(); #1;
    tests++; if (o_rd_eth !== 1'b0 || o_dec_valid !== 1'b1 || o_dec_action !== 2'b01) begin fails++; $display("FAIL bp_stall2: got rd=%b v=%b a=%b want 0/1/01", o_rd_eth, o_dec_valid, o_dec_action); end
    i_dec_ready = 1'b1; #1;
    tests++; if (o_rd_eth !== 1'b1) begin fails++; $display("FAIL bp_resume_pop: got rd=%b want 1", o_rd_eth); end
    cyc(); set_head(1'b1, 1'b1, 1'b1, 1'b0); #1;
    tests++; if (o_rd_eth !== 1'b1 || o_dec_valid !== 1'b1 || o_dec_action !== 2'b00) begin fails++; $display("FAIL bp_b2b1: got rd=%b v=%b a=%b want 1/1/00", o_rd_eth, o_dec_valid, o_dec_action); end
    cyc(); i_eth_valid = 1'b0; #1;
    tests++; if (o_dec_valid !== 1'b1 || o_dec_action !== 2'b10) begin fails++; $display("FAIL bp_b2b2: got v=%b a=%b want 1/10", o_dec_valid, o_dec_action); end
    cyc(); #1;
    tests++; if (o_dec_valid !== 1'b0 || o_drop_cnt !== 16'd1 || o_cpu_cnt !== 16'd1) begin fails++; $display("FAIL bp_end: got v=%b drop=%0d cpu=%0d want 0/1/1", o_dec_valid, o_drop_cnt, o_cpu_cnt); end
  endtask

  // Walk the drop counter up to FFFE with one drop decision per cycle, then push past the top.
  task automatic test_counter_sat();
    do_reset();
    i_eth_valid = 1'b1; set_head(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (65534) cyc();
    #1;
    tests++; if (o_drop_cnt !== 16'hFFFE) begin fails++; $display("FAIL sat_preset: got %h want fffe", o_drop_cnt); end
    repeat (3) cyc();
    i_eth_valid = 1'b0; #1;
    tests++; if (o_drop_cnt !== 16'hFFFF || o_cpu_cnt !== 16'd0) begin fails++; $display("FAIL sat_hold: got drop=%h cpu=%h want ffff/0000", o_drop_cnt, o_cpu_cnt); end
    cyc();
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_tvalid = 1'b1; i_tlast = 1'b1;
    cyc();
    i_tlast = 1'b0;
    cyc(); #1;
    tests++; if (o_pkt_word1 !== 1'b0 || o_outstanding !== 3'd2) begin fails++; $display("FAIL rm_in_body: got w1=%b out=%0d want 0/2", o_pkt_word1, o_outstanding); end
    reset = 1'b1; #1;
    tests++; if (o_outstanding !== 3'd0 || o_pkt_word1 !== 1'b1 || o_tready !== 1'b1) begin fails++; $display("FAIL rm_async_clear: got out=%0d w1=%b tready=%b want 0/1/1", o_outstanding, o_pkt_word1, o_tready); end
    cyc(); #1;
    tests++; if (o_outstanding !== 3'd0 || o_dec_valid !== 1'b0) begin fails++; $display("FAIL rm_held: got out=%0d v=%b want 0/0", o_outstanding, o_dec_valid); end
    reset = 1'b0; i_tlast = 1'b1; #1;
    tests++; if (o_pkt_word1 !== 1'b1) begin fails++; $display("FAIL rm_first_word: got %b want 1", o_pkt_word1); end
    cyc(); i_tvalid = 1'b0; #1;
    tests++; if (o_outstanding !== 3'd1) begin fails++; $display("FAIL rm_after: got %0d want 1", o_outstanding); end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #3;
    test_reset();
    cyc();
    reset = 1'b0;
    cyc();
    test_three_beat();
    test_single_beat();
    test_stall();
    test_simultaneous();
    test_decisions();
    test_back_to_back();
    test_reset_mid();
    test_counter_sat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
